stream_fifo: RTL and testbench

- Next-generation parametrised ready/valid FIFO for the utils library.
- Accepts any DEPTH ≥ 1, including non-powers-of-two.
- Exposes a registered occupancy count, almost-full/almost-empty flags and a synchronous flush.
- Implements FLOW (empty bypass) and PIPE (full pass-through) as fully specified modes. Used as the general buffering primitive between pipeline stages and in front of credit-based channels.

---
 rtl/utils_pkg.sv | 20 ++
 rtl/wrap_counter.sv | 31 +++
 rtl/stream_fifo.sv | 116 +++++++++++
 tb/tb_stream_fifo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
// utils_pkg: shared helpers for the utils library.
//   ptr_inc(ptr, depth) - advance a pointer over 0..depth-1 with explicit wrap
//   cnt_w(depth)        - width needed to hold a count 0..depth
//   ptr_w(depth)        - width needed to index 0..depth-1 (min 1 bit)
package utils_pkg;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    // Explicit wrap so non-power-of-two depths never index past the end.
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: modulo (MAX+1) counter used as a FIFO ring pointer.
//   clk_i   clock
//   rst_ni  async active-low reset, value -> 0
//   clear_i synchronous clear, wins over inc_i
//   inc_i   advance by one, wrapping MAX -> 0
//   value_o current value
// With MAX=0 the wrap always returns 0, so the register is a constant zero.
module wrap_counter
  import utils_pkg::*;
#(
  parameter int unsigned MAX = 1,
  localparam int unsigned W  = ptr_w(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] value_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      value_q <= '0;
    else if (clear_i) value_q <= '0;
    else if (inc_i)   value_q <= W'(ptr_inc(32'(value_q), MAX + 1));
  end

  assign value_o = value_q;

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: parametrised ready/valid FIFO, any DEPTH >= 1.
//   clk_i, rst_ni          clock, async active-low reset
//   flush_i                synchronous flush, blocks handshakes this cycle
//   enq_valid_i/enq_ready_o/enq_bits_i   enqueue side
//   deq_valid_o/deq_ready_i/deq_bits_o   dequeue side
//   count_o                registered occupancy 0..DEPTH
//   almost_full_o          count_o >= AF_THRESH
//   almost_empty_o         count_o <= AE_THRESH
// FLOW=1: an empty FIFO forwards enq_bits_i combinationally.
// PIPE=1: a full FIFO accepts an enqueue when the consumer is ready.
module stream_fifo
  import utils_pkg::*;
#(
  parameter type         T         = logic,
  parameter int unsigned DEPTH     = 2,
  parameter bit          PIPE      = 1'b0,
  parameter bit          FLOW      = 1'b0,
  parameter int unsigned AF_THRESH = DEPTH - 1,
  parameter int unsigned AE_THRESH = 1,
  localparam int unsigned CW       = cnt_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          enq_valid_i,
  output logic          enq_ready_o,
  input  T              enq_bits_i,
  output logic          deq_valid_o,
  input  logic          deq_ready_i,
  output T              deq_bits_o,
  output logic [CW-1:0] count_o,
  output logic          almost_full_o,
  output logic          almost_empty_o
);

  localparam int unsigned PW = ptr_w(DEPTH);

  // Elaboration-time parameter sanity
  if (DEPTH < 1 || DEPTH > 1024) begin : g_bad_depth
    $error("stream_fifo: DEPTH out of range");
  end
  if (AF_THRESH > DEPTH) begin : g_bad_af
    $error("stream_fifo: AF_THRESH > DEPTH");
  end
  if (AE_THRESH > DEPTH) begin : g_bad_ae
    $error("stream_fifo: AE_THRESH > DEPTH");
  end

  T              ram [DEPTH];
  logic [CW-1:0] count_q;
  logic [PW-1:0] enq_ptr, deq_ptr;
  logic          empty, full;
  logic          do_enq, do_deq, bypass, wr_en, rd_adv;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  assign enq_ready_o = !flush_i && (!full  || (PIPE && deq_ready_i));
  assign deq_valid_o = !flush_i && (!empty || (FLOW && enq_valid_i));

  assign do_enq = enq_valid_i && enq_ready_o;
  assign do_deq = deq_valid_o && deq_ready_i;

  // Empty FLOW pass-through consumes the beat without touching storage.
  assign bypass = FLOW && empty && do_enq && do_deq;
  assign wr_en  = do_enq && !bypass;
  assign rd_adv = do_deq && !bypass;

  assign deq_bits_o = (FLOW && empty) ? enq_bits_i : ram[deq_ptr];

  wrap_counter #(.MAX(DEPTH - 1)) u_enq_ptr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (flush_i),
    .inc_i   (wr_en),
    .value_o (enq_ptr)
  );

  wrap_counter #(.MAX(DEPTH - 1)) u_deq_ptr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (flush_i),
    .inc_i   (rd_adv),
    .value_o (deq_ptr)
  );

  // Storage is not reset. When PIPE and full, enq_ptr == deq_ptr; the read
  // of the old entry happens combinationally before this edge overwrites it.
  always_ff @(posedge clk_i) begin
    if (wr_en) ram[enq_ptr] <= enq_bits_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      count_q <= '0;
    else if (flush_i) count_q <= '0;
    else begin
      case ({wr_en, rd_adv})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o        = count_q;
  assign almost_full_o  = (count_q >= CW'(AF_THRESH));
  assign almost_empty_o = (count_q <= CW'(AE_THRESH));

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CW'(DEPTH));
  a_no_ovf : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (do_enq && full) |-> (PIPE && deq_ready_i));
`endif

endmodule

// File: tb/tb_stream_fifo.sv
module tb_stream_fifo;

  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DEPTH=3 plain FIFO
  logic       d3_flush, d3_ev, d3_er, d3_dv, d3_dr, d3_af, d3_ae;
  byte_t      d3_eb, d3_db;
  logic [1:0] d3_cnt;

  stream_fifo #(.T(byte_t), .DEPTH(3), .PIPE(1'b0), .FLOW(1'b0)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(d3_flush),
    .enq_valid_i(d3_ev), .enq_ready_o(d3_er), .enq_bits_i(d3_eb),
    .deq_valid_o(d3_dv), .deq_ready_i(d3_dr), .deq_bits_o(d3_db),
    .count_o(d3_cnt), .almost_full_o(d3_af), .almost_empty_o(d3_ae)
  );

  // DEPTH=2 FLOW FIFO
  logic       fl_flush, fl_ev, fl_er, fl_dv, fl_dr, fl_af, fl_ae;
  byte_t      fl_eb, fl_db;
  logic [1:0] fl_cnt;

  stream_fifo #(.T(byte_t), .DEPTH(2), .PIPE(1'b0), .FLOW(1'b1)) u_flow (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl_flush),
    .enq_valid_i(fl_ev), .enq_ready_o(fl_er), .enq_bits_i(fl_eb),
    .deq_valid_o(fl_dv), .deq_ready_i(fl_dr), .deq_bits_o(fl_db),
    .count_o(fl_cnt), .almost_full_o(fl_af), .almost_empty_o(fl_ae)
  );

  // DEPTH=2 PIPE FIFO
  logic       pp_flush, pp_ev, pp_er, pp_dv, pp_dr, pp_af, pp_ae;
  byte_t      pp_eb, pp_db;
  logic [1:0] pp_cnt;

  stream_fifo #(.T(byte_t), .DEPTH(2), .PIPE(1'b1), .FLOW(1'b0)) u_pipe (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(pp_flush),
    .enq_valid_i(pp_ev), .enq_ready_o(pp_er), .enq_bits_i(pp_eb),
    .deq_valid_o(pp_dv), .deq_ready_i(pp_dr), .deq_bits_o(pp_db),
    .count_o(pp_cnt), .almost_full_o(pp_af), .almost_empty_o(pp_ae)
  );

  initial begin
    d3_flush = 0; d3_ev = 0; d3_eb = '0; d3_dr = 0;
    fl_flush = 0; fl_ev = 0; fl_eb = '0; fl_dr = 0;
    pp_flush = 0; pp_ev = 0; pp_eb = '0; pp_dr = 0;

    // Reset state
    #2;
    check("rst_cnt", 32'(d3_cnt), 0);
    check("rst_er",  32'(d3_er), 1);
    check("rst_dv",  32'(d3_dv), 0);
    check("rst_af",  32'(d3_af), 0);
    check("rst_ae",  32'(d3_ae), 1);
    check("rst_pp_af", 32'(pp_af), 0);
    #20 rst_n = 1'b1;
    tick();

    // DEPTH=3 fill back-to-back, no dequeue
    d3_ev = 1; d3_eb = 8'h0A; tick();
    check("fill_cnt1", 32'(d3_cnt), 1);
    d3_eb = 8'h0B; tick();
    check("fill_cnt2", 32'(d3_cnt), 2);
    d3_eb = 8'h0C; tick();
    check("fill_cnt3", 32'(d3_cnt), 3);
    d3_ev = 0;
    check("full_er", 32'(d3_er), 0);
    check("full_af", 32'(d3_af), 1);
    check("full_ae", 32'(d3_ae), 0);
    check("full_dv", 32'(d3_dv), 1);

    // Drain in order
    d3_dr = 1; #1;
    check("drain0", 32'(d3_db), 32'h0A); tick();
    check("drain1", 32'(d3_db), 32'h0B); tick();
    check("drain2", 32'(d3_db), 32'h0C); tick();
    check("drain_cnt", 32'(d3_cnt), 0);
    check("drain_dv",  32'(d3_dv), 0);
    d3_dr = 0;

    // Pointer wrap: one lead-in enqueue, then 9 cycles of simultaneous enq/deq
    d3_ev = 1; d3_eb = 8'h10; tick();
    d3_dr = 1;
    for (int i = 0; i < 9; i++) begin
      d3_eb = 8'(8'h11 + i); #1;
      check("wrap_data", 32'(d3_db), 32'(8'h10 + i));
      tick();
      check("wrap_cnt", 32'(d3_cnt), 1);
    end
    d3_ev = 0; #1;
    check("wrap_last", 32'(d3_db), 32'h19);
    tick();
    check("wrap_empty", 32'(d3_cnt), 0);
    d3_dr = 0;

    // Flush with count=2 and a pending enqueue
    d3_ev = 1; d3_eb = 8'h21; tick();
    d3_eb = 8'h22; tick();
    check("pre_flush_cnt", 32'(d3_cnt), 2);
    d3_flush = 1; d3_eb = 8'h23; d3_dr = 1; #1;
    check("flush_er", 32'(d3_er), 0);
    check("flush_dv", 32'(d3_dv), 0);
    tick();
    d3_flush = 0; d3_ev = 0; d3_dr = 0; #1;
    check("post_flush_cnt", 32'(d3_cnt), 0);
    check("post_flush_ae",  32'(d3_ae), 1);
    check("post_flush_dv",  32'(d3_dv), 0);
    d3_ev = 1; d3_eb = 8'h24; tick();
    d3_ev = 0;
    check("post_flush_data", 32'(d3_db), 32'h24);
    d3_dr = 1; tick(); d3_dr = 0;
    check("post_flush_drain", 32'(d3_cnt), 0);

    // Async reset mid-stream at count=2
    d3_ev = 1; d3_eb = 8'h31; tick();
    d3_eb = 8'h32; tick();
    d3_ev = 0;
    check("pre_rst_cnt", 32'(d3_cnt), 2);
    #2 rst_n = 1'b0; #1;
    check("mid_rst_cnt", 32'(d3_cnt), 0);
    check("mid_rst_dv",  32'(d3_dv), 0);
    check("mid_rst_er",  32'(d3_er), 1);
    #2 rst_n = 1'b1;
    tick();
    d3_ev = 1; d3_eb = 8'h07; tick();
    d3_ev = 0;
    check("after_rst_dv",   32'(d3_dv), 1);
    check("after_rst_data", 32'(d3_db), 32'h07);
    d3_dr = 1; tick(); d3_dr = 0;

    // FLOW: empty bypass, consumer ready
    fl_ev = 1; fl_eb = 8'h05; fl_dr = 1; #1;
    check("flow_dv",   32'(fl_dv), 1);
    check("flow_data", 32'(fl_db), 32'h05);
    check("flow_er",   32'(fl_er), 1);
    tick();
    fl_ev = 0; fl_dr = 0;
    check("flow_cnt0", 32'(fl_cnt), 0);
    // FLOW: empty, consumer stalled -> stored
    fl_ev = 1; fl_eb = 8'h05; #1;
    check("flow_stall_dv",   32'(fl_dv), 1);
    check("flow_stall_data", 32'(fl_db), 32'h05);
    tick();
    fl_ev = 0; fl_eb = 8'hEE; #1;
    check("flow_cnt1",  32'(fl_cnt), 1);
    check("flow_store", 32'(fl_db), 32'h05);
    fl_dr = 1; tick(); fl_dr = 0;
    check("flow_drain", 32'(fl_cnt), 0);

    // PIPE: full, simultaneous deq+enq
    pp_ev = 1; pp_eb = 8'h01; tick();
    pp_eb = 8'h02; tick();
    check("pipe_full_cnt", 32'(pp_cnt), 2);
    check("pipe_full_er",  32'(pp_er), 0);
    pp_eb = 8'h03; pp_dr = 1; #1;
    check("pipe_er",   32'(pp_er), 1);
    check("pipe_deq1", 32'(pp_db), 32'h01);
    tick();
    pp_ev = 0; #1;
    check("pipe_cnt2", 32'(pp_cnt), 2);
    check("pipe_deq2", 32'(pp_db), 32'h02);
    tick();
    check("pipe_deq3", 32'(pp_db), 32'h03);
    check("pipe_cnt1", 32'(pp_cnt), 1);
    tick();
    check("pipe_cnt0", 32'(pp_cnt), 0);
    pp_dr = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
